// File: rtl/button_debounce_if.sv
// button_debounce_if: raw button levels in, debounced levels and strobes out.
// slave (debouncer): BTN in; State/Pressed/Released out. master: the reverse.
interface button_debounce_if #(
  parameter int N = 4
) ();
  logic [N-1:0] BTN;
  logic [N-1:0] State;
  logic [N-1:0] Pressed;
  logic [N-1:0] Released;

  modport master (
    output BTN,
    input  State,
    input  Pressed,
    input  Released
  );

  modport slave (
    input  BTN,
    output State,
    output Pressed,
    output Released
  );
endinterface

// File: rtl/button_debounce.sv
// button_debounce: per-channel 2-flop sync + stability counter + edge strobes.
// Ports: Clk, Reset (sync, active-high), bus.slave (BTN in; State/Pressed/Released out).
module button_debounce #(
  parameter int N             = 4,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic          Clk,
  input  logic          Reset,
  button_debounce_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [N-1:0]  s1_q, s2_q;
  logic [N-1:0]  state_q, state_d;
  logic [N-1:0]  press_q, press_d;
  logic [N-1:0]  rel_q, rel_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  // Any cycle where s2 agrees with State clears the count, so a
  // bounce back to the accepted level restarts qualification.
  always_comb begin
    state_d = state_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != state_q[i]) begin
        if (cnt_q[i] == LAST) begin
          state_d[i] = s2_q[i];
          press_d[i] = s2_q[i];
          rel_d[i]   = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      state_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < N; i++)
        cnt_q[i] <= '0;
    end else begin
      s1_q    <= bus.BTN;
      s2_q    <= s1_q;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < N; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.State    = state_q;
  assign bus.Pressed  = press_q;
  assign bus.Released = rel_q;
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed steps; expected strobes queued at drive time
// and retired on the cycle they fall due; outputs checked every cycle.
module tb_button_debounce;
  localparam int N  = 4;
  localparam int SC = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [N-1:0] exp_state = '0;

  typedef struct {
    int           at;
    logic [N-1:0] p;
    logic [N-1:0] r;
  } ev_t;
  ev_t q[$];

  button_debounce_if #(.N(N)) bus ();

  button_debounce #(
    .N(N),
    .STABLE_CYCLES(SC)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  // A level change driven now is first sampled on edge cyc+1 (k)
  // and must be accepted on edge k+SC+1.
  task automatic push_ev(input logic [N-1:0] p, input logic [N-1:0] r);
    ev_t e;
    e.at = cyc + SC + 2;
    e.p  = p;
    e.r  = r;
    q.push_back(e);
  endtask

  task automatic tick();
    logic rst_s;
    logic [N-1:0] ep, er;
    rst_s = Reset;
    @(posedge Clk);
    cyc++;
    ep = '0;
    er = '0;
    if (rst_s) begin
      exp_state = '0;
      q.delete();
    end else begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].at == cyc) begin
          ep |= q[i].p;
          er |= q[i].r;
          q.delete(i);
        end
      end
    end
    exp_state = (exp_state | ep) & ~er;
    #1;
    checks++;
    assert (bus.State === exp_state) else begin
      errors++;
      $error("FAIL state cyc=%0d got=%h exp=%h", cyc, bus.State, exp_state);
    end
    checks++;
    assert (bus.Pressed === ep) else begin
      errors++;
      $error("FAIL pressed cyc=%0d got=%h exp=%h", cyc, bus.Pressed, ep);
    end
    checks++;
    assert (bus.Released === er) else begin
      errors++;
      $error("FAIL released cyc=%0d got=%h exp=%h", cyc, bus.Released, er);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // 1: reset with all buttons held, then fresh press on release
    bus.BTN = 4'hF;
    Reset   = 1'b1;
    run(3);
    Reset = 1'b0;
    push_ev(4'hF, 4'h0);
    run(10);
    bus.BTN = 4'h0;
    push_ev(4'h0, 4'hF);
    run(10);

    // 2: clean press/release on ch0
    bus.BTN[0] = 1'b1;
    push_ev(4'h1, 4'h0);
    run(20);
    bus.BTN[0] = 1'b0;
    push_ev(4'h0, 4'h1);
    run(10);

    // 3: bounce rejection on ch1
    bus.BTN[1] = 1'b1; tick();
    bus.BTN[1] = 1'b0; tick();
    bus.BTN[1] = 1'b1; tick();
    bus.BTN[1] = 1'b0;
    run(12);

    // 4: bounce then settle on ch2 (count reaches SC-1 then drops)
    bus.BTN[2] = 1'b1; tick();
    bus.BTN[2] = 1'b1; tick();
    bus.BTN[2] = 1'b1; tick();
    bus.BTN[2] = 1'b0; tick();
    bus.BTN[2] = 1'b1;
    push_ev(4'h4, 4'h0);
    run(10);

    // 5: press ch0, then press ch3 and release ch0 together
    bus.BTN[0] = 1'b1;
    push_ev(4'h1, 4'h0);
    run(10);
    bus.BTN[3] = 1'b1;
    bus.BTN[0] = 1'b0;
    push_ev(4'h8, 4'h1);
    run(10);

    // 6: reset one edge before ch1 would be accepted
    bus.BTN[1] = 1'b1;
    run(5);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    push_ev(4'hE, 4'h0);
    run(10);

    checks++;
    assert (q.size() === 0) else begin
      errors++;
      $error("FAIL pending got=%0d exp=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
